lut_sxx_config_loader: RTL and testbench

//   Serial-to-parallel configuration loader sitting directly upstream of a fracturable
//   SXX LUT. Accepts a frame of CFG_WIDTH bits over a valid/ready serial link, assembles
//   it into config_in, then issues a single-cycle config_en commit pulse. The LUT

---
 rtl/lut_sxx_config_loader_if.sv | 25 ++
 rtl/lut_sxx_config_loader.sv | 90 +++++++++
 tb/tb_lut_sxx_config_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lut_sxx_config_loader_if.sv
// Serial configuration link between a frame source and the SXX LUT config loader.
// The master drives the serial bits; the slave (loader) returns the assembled word and strobes.
interface lut_sxx_config_loader_if #(
    parameter int unsigned CFG_WIDTH = 33
);
    logic                 start;
    logic                 abort;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic [CFG_WIDTH-1:0] config_in;
    logic                 config_en;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, bit_in, bit_valid,
        input  bit_ready, config_in, config_en, busy, done
    );

    modport slave (
        input  start, abort, bit_in, bit_valid,
        output bit_ready, config_in, config_en, busy, done
    );
endinterface

// File: rtl/lut_sxx_config_loader.sv
// Serial-to-parallel loader for a fracturable SXX LUT: shifts in one MSB-first frame,
// then issues a single-cycle commit strobe. Word MSB is the fracture (split) bit.
module lut_sxx_config_loader #(
    parameter int unsigned INPUTS    = 4,
    parameter int unsigned MEM_SIZE  = 1 << INPUTS,
    parameter int unsigned CFG_WIDTH = 2 * MEM_SIZE + 1
) (
    input  logic                     config_clk,
    input  logic                     config_rst,
    lut_sxx_config_loader_if.slave   cfg
);
    localparam int unsigned CNT_W = $clog2(CFG_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [CFG_WIDTH-1:0] config_in_q;
    logic                 bit_ready_q;
    logic                 config_en_q;
    logic                 done_q;
    logic                 busy_q;

    // All outputs are registered alongside the state so nothing combinational reaches the LUT.
    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            config_in_q <= '0;
            bit_ready_q <= 1'b0;
            config_en_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            config_en_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg.start) begin
                        state_q     <= SHIFT;
                        count_q     <= '0;
                        bit_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Abort wins over a bit offered in the same cycle; partial word is kept.
                    if (cfg.abort) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        bit_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (cfg.bit_valid && bit_ready_q) begin
                        config_in_q <= {config_in_q[CFG_WIDTH-2:0], cfg.bit_in};
                        if (count_q == LAST_BIT) begin
                            state_q     <= COMMIT;
                            count_q     <= '0;
                            bit_ready_q <= 1'b0;
                            config_en_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    count_q     <= '0;
                    bit_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.bit_ready = bit_ready_q;
    assign cfg.config_in = config_in_q;
    assign cfg.config_en = config_en_q;
    assign cfg.done      = done_q;
    assign cfg.busy      = busy_q;
endmodule

// File: tb/tb_lut_sxx_config_loader.sv
// Directed + randomized bench for the SXX LUT config loader, with a bit-queue word model
// and a behavioural fracturable LUT capturing on the commit strobe.
module tb_lut_sxx_config_loader;
    localparam int unsigned W = 33;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_sxx_config_loader_if #(.CFG_WIDTH(W)) bus ();

    lut_sxx_config_loader #(.INPUTS(4)) dut (
        .config_clk (clk),
        .config_rst (rst),
        .cfg        (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] mdl;       // expected contents of config_in
    logic [W-1:0] lut_cfg;   // word held by the behavioural LUT
    int en_pulses = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) lut_cfg <= '0;
        else if (bus.config_en) begin
            lut_cfg   <= bus.config_in;
            en_pulses <= en_pulses + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fractured: two 16-entry tables on shared inputs. Cascaded: one 32-entry table.
    function automatic logic [1:0] lut_eval(input logic [W-1:0] c, input logic [4:0] in);
        logic [1:0] r;
        if (c[W-1]) r = {c[16 + int'(in[3:0])], c[int'(in[3:0])]};
        else        r = {c[int'(in)], c[int'(in)]};
        return r;
    endfunction

    // mode 0: back-to-back bits, 1: valid every other cycle, 2: random valid + stray start
    task automatic send_frame(input logic [W-1:0] w, input int mode, input int abort_after,
                              output int cycles);
        int n;
        logic v;
        n = 0;
        cycles = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", 64'(bus.busy), 64'd1);
        chk("start_ready", 64'(bus.bit_ready), 64'd1);
        while (n < W && cycles < 400) begin
            if (abort_after == n) begin
                bus.abort     = 1'b1;
                bus.bit_valid = 1'b1;
                bus.bit_in    = ~w[W-1-n];
                step();
                bus.abort     = 1'b0;
                bus.bit_valid = 1'b0;
                chk("abort_no_en", 64'(bus.config_en), 64'd0);
                chk("abort_busy", 64'(bus.busy), 64'd0);
                chk("abort_ready", 64'(bus.bit_ready), 64'd0);
                chk("abort_word", 64'(bus.config_in), 64'(mdl));
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) bus.start = 1'($urandom_range(0, 1));
            bus.bit_valid = v;
            bus.bit_in    = v ? w[W-1-n] : 1'($urandom_range(0, 1));
            step();
            cycles++;
            if (v) begin
                mdl = {mdl[W-2:0], w[W-1-n]};
                n++;
            end
            if (n < W) begin
                chk("shift_word", 64'(bus.config_in), 64'(mdl));
                chk("shift_no_en", 64'(bus.config_en), 64'd0);
            end
        end
        bus.bit_valid = 1'b0;
        bus.start     = 1'b0;
        if (n < W) chk("frame_timeout", 64'(n), 64'(W));
        chk("commit_en", 64'(bus.config_en), 64'd1);
        chk("commit_done", 64'(bus.done), 64'd1);
        chk("commit_word", 64'(bus.config_in), 64'(w));
        chk("commit_ready", 64'(bus.bit_ready), 64'd0);
        chk("commit_busy", 64'(bus.busy), 64'd1);
        step();
        chk("post_en", 64'(bus.config_en), 64'd0);
        chk("post_done", 64'(bus.done), 64'd0);
        chk("post_busy", 64'(bus.busy), 64'd0);
        chk("post_word", 64'(bus.config_in), 64'(w));
    endtask

    initial begin
        int cyc;
        int pulses_before;
        logic [W-1:0] w;
        logic [4:0] in;

        bus.start = 1'b0; bus.abort = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
        rst = 1'b1;
        mdl = '0;
        step();
        step();
        chk("rst_word", 64'(bus.config_in), 64'd0);
        chk("rst_en", 64'(bus.config_en), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.bit_ready), 64'd0);
        rst = 1'b0;

        // Bits offered while idle must be ignored.
        for (int i = 0; i < 5; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            step();
            chk("idle_word", 64'(bus.config_in), 64'd0);
            chk("idle_ready", 64'(bus.bit_ready), 64'd0);
        end
        bus.bit_valid = 1'b0;

        send_frame(33'h1_A5A5_3C3C, 0, -1, cyc);
        chk("b2b_cycles", 64'(cyc), 64'd33);
        send_frame(33'h1_A5A5_3C3C, 1, -1, cyc);
        chk("gap_cycles", 64'(cyc), 64'd65);

        // Abort after 10 bits, then a clean frame.
        pulses_before = en_pulses;
        send_frame(33'h1_5555_AAAA, 0, 10, cyc);
        step();
        chk("abort_pulses", 64'(en_pulses), 64'(pulses_before));
        send_frame(33'h0_0000_FFFF, 0, -1, cyc);
        chk("after_abort_split", 64'(lut_cfg[W-1]), 64'd0);
        chk("after_abort_lut", 64'(lut_cfg), 64'h0_0000_FFFF);

        // Reset mid-frame at bit 20.
        pulses_before = en_pulses;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'($urandom_range(0, 1));
            step();
        end
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_word", 64'(bus.config_in), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_ready", 64'(bus.bit_ready), 64'd0);
        chk("midrst_en", 64'(bus.config_en), 64'd0);
        step();
        rst = 1'b0;
        mdl = '0;
        chk("midrst_pulses", 64'(en_pulses), 64'(pulses_before));
        send_frame(33'h1_A5A5_3C3C, 0, -1, cyc);

        // Random frames with random gaps and stray start pulses.
        for (int f = 0; f < 6; f++) begin
            w = W'({$urandom, $urandom});
            send_frame(w, 2, -1, cyc);
            chk("rand_lut_word", 64'(lut_cfg), 64'(w));
        end

        // LUT behaviour for a split and a cascaded configuration.
        for (int s = 0; s < 2; s++) begin
            w = W'({$urandom, $urandom});
            w[W-1] = (s == 0);
            send_frame(w, 0, -1, cyc);
            for (int k = 0; k < 8; k++) begin
                in = 5'($urandom_range(0, 31));
                chk(s == 0 ? "lut_fractured" : "lut_cascaded",
                    64'(lut_eval(lut_cfg, in)), 64'(lut_eval(w, in)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
